// File: rtl/pkt_reader_pkg.sv
// Shared types and constants for the packet FIFO reader: FSM states, counter width,
// default stream geometry and the empty-field width helper.
package pkt_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } rd_state_e;

    localparam int CNT_W                = 32;
    localparam int DEF_SYMBOLS_PER_BEAT = 64;
    localparam int DEF_BITS_PER_SYMBOL  = 8;
    localparam int DEF_DATA_W           = DEF_SYMBOLS_PER_BEAT * DEF_BITS_PER_SYMBOL;
    localparam int DEF_EMPTY_W          = $clog2(DEF_SYMBOLS_PER_BEAT);

    // A one-symbol beat still needs a 1-bit empty field to keep the port legal.
    function automatic int empty_w(input int symbols);
        return (symbols > 1) ? $clog2(symbols) : 1;
    endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST packet stream bundle; tx drives a stream, rx consumes one.
interface avl_stream_if #(
    parameter int DATA_W  = pkt_reader_pkg::DEF_DATA_W,
    parameter int EMPTY_W = pkt_reader_pkg::DEF_EMPTY_W
);
    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               ready;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               almost_full;

    modport tx (output data, valid, sop, eop, empty, input ready);
    modport rx (input data, valid, sop, eop, empty, almost_full, output ready);
endinterface

// File: rtl/avlstrm_pipe_reg.sv
// One-beat Avalon-ST output register holding data/sop/eop/empty.
// Latency: 1 cycle from accepted input to out_vld.
// Backpressure: in_rdy = ~out_vld | out_rdy, combinational; payload holds while stalled.
module avlstrm_pipe_reg #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DATA_W-1:0]  in_dat,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DATA_W-1:0]  out_dat,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty
);
    logic               vld_q, vld_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;

    assign in_rdy = ~vld_q | out_rdy;

    always_comb begin
        vld_d   = vld_q;
        dat_d   = dat_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        empty_d = empty_q;
        if (in_rdy) begin
            vld_d = in_vld;
            if (in_vld) begin
                dat_d   = in_dat;
                sop_d   = in_sop;
                eop_d   = in_eop;
                empty_d = in_empty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            dat_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
        end else begin
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
        end
    end

    assign out_vld   = vld_q;
    assign out_dat   = dat_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_empty = empty_q;

endmodule

// File: rtl/pkt_fifo_reader_avlstrm.sv
// Packet FIFO reader: enforces sop/eop framing, drops or truncates bad traffic, counts events.
// Optional length limit via PKT_READER_LEN_CHECK_EN. Latency: 1 cycle through the output register.
// Backpressure: in.ready = ~out_valid | out.ready; discarded beats still need in.ready.
module pkt_fifo_reader_avlstrm
    import pkt_reader_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = DEF_SYMBOLS_PER_BEAT,
    parameter int BITS_PER_SYMBOL  = DEF_BITS_PER_SYMBOL,
    parameter int MAX_PKT_BEATS    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    avl_stream_if.rx         in,
    avl_stream_if.tx         out,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int DATA_W  = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
    localparam int EMPTY_W = empty_w(SYMBOLS_PER_BEAT);

    rd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               in_rdy;
    logic               in_acc;
    logic               fwd_vld;
    logic               fwd_sop;
    logic               fwd_eop;
    logic [EMPTY_W-1:0] fwd_empty;
    logic               err_inc;
    logic               drop_inc;
    logic               len_hit;

    logic               out_vld;
    logic [DATA_W-1:0]  out_dat;
    logic               out_sop;
    logic               out_eop;
    logic [EMPTY_W-1:0] out_empty;

    assign in.ready = in_rdy;
    assign in_acc   = in.valid & in_rdy;

`ifdef PKT_READER_LEN_CHECK_EN
    localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    // The count only lives while a packet is open; any exit from PKT clears it.
    always_comb begin
        beat_cnt_d = '0;
        if (state_d == PKT)
            beat_cnt_d = fwd_vld ? beat_cnt_q + BEAT_W'(1) : beat_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_cnt_q <= '0;
        else        beat_cnt_q <= beat_cnt_d;
    end

    assign len_hit = (beat_cnt_q == BEAT_W'(MAX_PKT_BEATS - 1));
`else
    assign len_hit = 1'b0;

    // MAX_PKT_BEATS has no effect without the length check; this keeps it referenced.
    if (MAX_PKT_BEATS < 2) begin : g_max_pkt_beats_unused
    end
`endif

    always_comb begin
        state_d   = state_q;
        fwd_vld   = 1'b0;
        fwd_sop   = 1'b0;
        fwd_eop   = in.eop;
        fwd_empty = in.eop ? in.empty : '0;
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        if (in_acc) begin
            case (state_q)
                IDLE: begin
                    if (in.sop) begin
                        fwd_vld = 1'b1;
                        fwd_sop = 1'b1;
                        if (!in.eop) state_d = PKT;
                    end else begin
                        drop_inc = 1'b1;
                        err_inc  = 1'b1;
                        if (!in.eop) state_d = DROP;
                    end
                end
                PKT: begin
                    fwd_vld = 1'b1;
                    if (in.sop) begin
                        // A new sop closes the open packet; the new packet is discarded.
                        fwd_eop   = 1'b1;
                        fwd_empty = '0;
                        err_inc   = 1'b1;
                        state_d   = in.eop ? IDLE : DROP;
                    end else if (in.eop) begin
                        state_d = IDLE;
                    end else if (len_hit) begin
                        fwd_eop   = 1'b1;
                        fwd_empty = '0;
                        err_inc   = 1'b1;
                        state_d   = DROP;
                    end
                end
                DROP: begin
                    drop_inc = 1'b1;
                    if (in.eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(out_vld & out.ready & out_eop);
        err_cnt_d  = err_cnt_q + CNT_W'(err_inc);
        drop_cnt_d = drop_cnt_q + CNT_W'(drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    avlstrm_pipe_reg #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W)
    ) u_pipe_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (fwd_vld),
        .in_rdy    (in_rdy),
        .in_dat    (in.data),
        .in_sop    (fwd_sop),
        .in_eop    (fwd_eop),
        .in_empty  (fwd_empty),
        .out_vld   (out_vld),
        .out_rdy   (out.ready),
        .out_dat   (out_dat),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty)
    );

    assign out.valid = out_vld;
    assign out.data  = out_dat;
    assign out.sop   = out_sop;
    assign out.eop   = out_eop;
    assign out.empty = out_empty;

    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule
